// File: rtl/glb_core_strm_rd_responder.sv
// ---------------------------------------------------------------------------
// glb_core_strm_rd_responder
//
// Tile-side responder for streaming read-request (rdrq) packets arriving from
// the tile router. Requests addressed to this tile are queued, issued to the
// bank read port when it is free, and the read results are returned as rdrs
// packets in request order.
//
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   clk_en               global clock enable, all state holds while low
//   glb_tile_id          id of this tile
//   rdrq_rd_en/addr      incoming read request packet
//   bank_rd_ready        bank read port can accept a read this cycle
//   bank_rd_en/addr      bank read issue (combinational) and in-tile address
//   bank_rd_data         bank read data, RD_LATENCY cycles after issue
//   rdrs_rd_data_valid   registered one-cycle response strobe
//   rdrs_rd_data         registered response data, held between responses
//   err_overflow         sticky flag: a claimed request was dropped
//   busy                 queue non-empty or a read still in flight
// ---------------------------------------------------------------------------
module glb_core_strm_rd_responder #(
    parameter int ADDR_WIDTH          = 22,
    parameter int DATA_WIDTH          = 64,
    parameter int TILE_SEL_ADDR_WIDTH = 5,
    parameter int TILE_SEL_LSB        = 17,
    parameter int RD_LATENCY          = 2,
    parameter int REQ_FIFO_DEPTH      = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clk_en,
    input  logic [TILE_SEL_ADDR_WIDTH-1:0] glb_tile_id,
    input  logic                           rdrq_rd_en,
    input  logic [ADDR_WIDTH-1:0]          rdrq_rd_addr,
    input  logic                           bank_rd_ready,
    output logic                           bank_rd_en,
    output logic [TILE_SEL_LSB-1:0]        bank_rd_addr,
    input  logic [DATA_WIDTH-1:0]          bank_rd_data,
    output logic                           rdrs_rd_data_valid,
    output logic [DATA_WIDTH-1:0]          rdrs_rd_data,
    output logic                           err_overflow,
    output logic                           busy
);

    localparam int PTR_W = $clog2(REQ_FIFO_DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    logic [PTR_W:0]            wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]            rd_ptr_q, rd_ptr_d;
    logic [TILE_SEL_LSB-1:0]   mem_q [REQ_FIFO_DEPTH];
    logic [TILE_SEL_LSB-1:0]   mem_d [REQ_FIFO_DEPTH];
    logic [RD_LATENCY-1:0]     pipe_q, pipe_d;
    logic                      rdrs_valid_q, rdrs_valid_d;
    logic [DATA_WIDTH-1:0]     rdrs_data_q, rdrs_data_d;
    logic                      err_q, err_d;

    logic claim_s;
    logic empty_s;
    logic full_s;
    logic issue_s;
    logic push_s;
    logic drop_s;

    // Request decode, queue status and issue/push/drop decisions.
    always_comb begin
        claim_s = rdrq_rd_en &
                  (rdrq_rd_addr[TILE_SEL_LSB +: TILE_SEL_ADDR_WIDTH] == glb_tile_id);
        empty_s = (wr_ptr_q == rd_ptr_q);
        full_s  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                  (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        issue_s = clk_en & ~empty_s & bank_rd_ready;
        // A full queue still accepts a claim when the head pops on the same edge.
        push_s  = clk_en & claim_s & (~full_s | issue_s);
        drop_s  = clk_en & claim_s & full_s & ~issue_s;
    end

    // Bank port and status outputs.
    always_comb begin
        bank_rd_en = issue_s;
        if (empty_s) begin
            bank_rd_addr = '0;
        end else begin
            bank_rd_addr = mem_q[rd_ptr_q[PTR_W-1:0]];
        end
        busy               = ~empty_s | (|pipe_q);
        rdrs_rd_data_valid = rdrs_valid_q;
        rdrs_rd_data       = rdrs_data_q;
        err_overflow       = err_q;
    end

    // Next-state computation for queue, latency pipe and response registers.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        mem_d        = mem_q;
        pipe_d       = pipe_q;
        rdrs_valid_d = rdrs_valid_q;
        rdrs_data_d  = rdrs_data_q;
        err_d        = err_q;
        if (clk_en) begin
            if (push_s) begin
                mem_d[wr_ptr_q[PTR_W-1:0]] = rdrq_rd_addr[TILE_SEL_LSB-1:0];
                wr_ptr_d                   = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (issue_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            // Bit k set means a read was issued k+1 enabled cycles ago; the top
            // bit marks the cycle in which bank_rd_data carries that result.
            pipe_d[0] = issue_s;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
            if (pipe_q[RD_LATENCY-1]) begin
                rdrs_valid_d = 1'b1;
                rdrs_data_d  = bank_rd_data;
            end else begin
                rdrs_valid_d = 1'b0;
                rdrs_data_d  = rdrs_data_q;
            end
            err_d = err_q | drop_s;
        end else begin
            err_d = err_q;
        end
    end

    // State registers with synchronous reset; reset flushes queue and pipe.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            for (int i = 0; i < REQ_FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            pipe_q       <= '0;
            rdrs_valid_q <= 1'b0;
            rdrs_data_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            mem_q        <= mem_d;
            pipe_q       <= pipe_d;
            rdrs_valid_q <= rdrs_valid_d;
            rdrs_data_q  <= rdrs_data_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_glb_core_strm_rd_responder.sv
// ---------------------------------------------------------------------------
// Testbench for glb_core_strm_rd_responder. Stimulus is driven just after the
// falling edge; a reference model tracks queue occupancy and the ordered list
// of expected response data; a monitor on the falling edge compares every
// response strobe and the overflow flag against that model.
// ---------------------------------------------------------------------------
module tb_glb_core_strm_rd_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 4;
    localparam logic [4:0] MY_TILE = 5'd3;

    logic        clk;
    logic        reset;
    logic        clk_en;
    logic [4:0]  glb_tile_id;
    logic        rdrq_rd_en;
    logic [21:0] rdrq_rd_addr;
    logic        bank_rd_ready;
    logic        bank_rd_en;
    logic [16:0] bank_rd_addr;
    logic [63:0] bank_rd_data;
    logic        rdrs_rd_data_valid;
    logic [63:0] rdrs_rd_data;
    logic        err_overflow;
    logic        busy;

    glb_core_strm_rd_responder dut (
        .clk                (clk),
        .reset              (reset),
        .clk_en             (clk_en),
        .glb_tile_id        (glb_tile_id),
        .rdrq_rd_en         (rdrq_rd_en),
        .rdrq_rd_addr       (rdrq_rd_addr),
        .bank_rd_ready      (bank_rd_ready),
        .bank_rd_en         (bank_rd_en),
        .bank_rd_addr       (bank_rd_addr),
        .bank_rd_data       (bank_rd_data),
        .rdrs_rd_data_valid (rdrs_rd_data_valid),
        .rdrs_rd_data       (rdrs_rd_data),
        .err_overflow       (err_overflow),
        .busy               (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bank contents: every in-tile address holds a distinct, recognisable word.
    function automatic logic [63:0] bank_fn(input logic [16:0] a);
        return {a, 15'h5A5A, a ^ 17'h15555, 15'h2B3C};
    endfunction

    // Bank model: a read accepted in enabled cycle T shows its data in T+LAT.
    logic        bv_q [LAT];
    logic [16:0] ba_q [LAT];
    logic [63:0] garbage_q;
    initial begin
        for (int k = 0; k < LAT; k++) begin
            bv_q[k] = 1'b0;
            ba_q[k] = '0;
        end
        garbage_q = 64'hDEAD_BEEF_0BAD_F00D;
    end
    always @(posedge clk) begin
        if (clk_en) begin
            bv_q[0] <= bank_rd_en;
            ba_q[0] <= bank_rd_addr;
            for (int k = 1; k < LAT; k++) begin
                bv_q[k] <= bv_q[k-1];
                ba_q[k] <= ba_q[k-1];
            end
        end
        garbage_q <= {$urandom, $urandom};
    end
    assign bank_rd_data = bv_q[LAT-1] ? bank_fn(ba_q[LAT-1]) : garbage_q;

    // Reference model state and scoreboard.
    int          occ;
    logic [63:0] exp_q [$];
    bit          ovf_model;
    int          vectors;
    int          miscompares;
    int          resp_count;
    bit          started;
    logic        en_at_edge;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) en_at_edge <= clk_en;

    // Monitor: every enabled-edge response strobe must match the oldest
    // expected entry; the overflow flag must track the model at all times.
    always @(negedge clk) begin
        if (started) begin
            if (en_at_edge && rdrs_rd_data_valid) begin
                resp_count++;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_rdrs: got data %h expected no response at %0t",
                             rdrs_rd_data, $time);
                end else begin
                    check("rdrs_data", rdrs_rd_data, exp_q.pop_front());
                end
            end
            check("err_overflow", {63'd0, err_overflow}, {63'd0, ovf_model});
        end
    end

    // Apply one cycle of inputs, update the model, return one cycle later.
    task automatic drive(input bit en, input bit rq, input logic [21:0] addr, input bit rdy);
        bit pop;
        bit claim;
        clk_en        = en;
        rdrq_rd_en    = rq;
        rdrq_rd_addr  = addr;
        bank_rd_ready = rdy;
        if (en) begin
            pop   = (occ > 0) && rdy;
            claim = rq && (addr[21:17] == glb_tile_id);
            if (claim) begin
                if (occ < DEPTH || pop) begin
                    exp_q.push_back(bank_fn(addr[16:0]));
                    occ++;
                end else begin
                    ovf_model = 1'b1;
                end
            end
            if (pop) occ--;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input bit rdy);
        drive(1'b1, 1'b0, 22'd0, rdy);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        rdrq_rd_en = 1'b0;
        clk_en     = 1'b1;
        occ        = 0;
        ovf_model  = 1'b0;
        exp_q.delete();
        @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 40) begin
            idle(1'b1);
            n++;
        end
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        idle(1'b1);
        check({name, "_busy_idle"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        int base;
        vectors     = 0;
        miscompares = 0;
        resp_count  = 0;
        started     = 1'b0;
        occ         = 0;
        ovf_model   = 1'b0;
        reset         = 1'b1;
        clk_en        = 1'b1;
        glb_tile_id   = MY_TILE;
        rdrq_rd_en    = 1'b0;
        rdrq_rd_addr  = '0;
        bank_rd_ready = 1'b1;
        @(negedge clk);
        #1;
        do_reset();
        started = 1'b1;

        // Reset state.
        check("rst_valid", {63'd0, rdrs_rd_data_valid}, 64'd0);
        check("rst_data", rdrs_rd_data, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_bank_en", {63'd0, bank_rd_en}, 64'd0);
        check("rst_bank_addr", {47'd0, bank_rd_addr}, 64'd0);

        // Single request: issue one cycle after claim, response four after.
        drive(1'b1, 1'b1, {MY_TILE, 17'h00040}, 1'b1);
        check("single_issue_en", {63'd0, bank_rd_en}, 64'd1);
        check("single_issue_addr", {47'd0, bank_rd_addr}, 64'h40);
        check("single_busy", {63'd0, busy}, 64'd1);
        for (int k = 2; k <= 5; k++) begin
            idle(1'b1);
            check("single_valid_time", {63'd0, rdrs_rd_data_valid}, (k == 4) ? 64'd1 : 64'd0);
            if (k == 4) check("single_data", rdrs_rd_data, bank_fn(17'h00040));
        end

        // Foreign tile: ignored entirely.
        drive(1'b1, 1'b1, {5'd5, 17'h00123}, 1'b1);
        check("foreign_bank_en", {63'd0, bank_rd_en}, 64'd0);
        check("foreign_busy", {63'd0, busy}, 64'd0);
        repeat (4) idle(1'b1);
        check("foreign_busy_late", {63'd0, busy}, 64'd0);

        // Back-to-back: 8 claims give 8 consecutive responses starting at C+4.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, {MY_TILE, 17'($urandom_range(0, 131071))}, 1'b1);
            check("b2b_valid", {63'd0, rdrs_rd_data_valid}, (i >= 3) ? 64'd1 : 64'd0);
        end
        for (int j = 0; j < 4; j++) begin
            idle(1'b1);
            check("b2b_tail_valid", {63'd0, rdrs_rd_data_valid}, (j < 3) ? 64'd1 : 64'd0);
        end
        check("b2b_no_ovf", {63'd0, err_overflow}, 64'd0);
        drain("b2b");

        // Stall/overflow: 5 claims with the bank stalled, 5th is dropped.
        base = resp_count;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, {MY_TILE, 17'(16'h1000 + i)}, 1'b0);
        end
        check("stall_ovf_set", {63'd0, err_overflow}, 64'd1);
        check("stall_busy", {63'd0, busy}, 64'd1);
        check("stall_no_issue", {63'd0, bank_rd_en}, 64'd0);
        drain("stall");
        check("stall_resp_count", 64'(resp_count - base), 64'd4);

        // Full queue with a simultaneous pop and claim: nothing dropped.
        do_reset();
        base = resp_count;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, {MY_TILE, 17'(17'h0A000 + i)}, 1'b0);
        end
        drive(1'b1, 1'b1, {MY_TILE, 17'h0A0FF}, 1'b1);
        check("fullpop_no_ovf", {63'd0, err_overflow}, 64'd0);
        drain("fullpop");
        check("fullpop_resp_count", 64'(resp_count - base), 64'd5);

        // Clock gating: three disabled cycles shift the response by three.
        drive(1'b1, 1'b1, {MY_TILE, 17'h00777}, 1'b1);
        check("gate_valid_t1", {63'd0, rdrs_rd_data_valid}, 64'd0);
        for (int k = 1; k <= 8; k++) begin
            if (k <= 3) drive(1'b0, 1'b1, {MY_TILE, 17'h01111}, 1'b1);
            else        idle(1'b1);
            check("gate_valid_time", {63'd0, rdrs_rd_data_valid}, (k + 1 == 7) ? 64'd1 : 64'd0);
            if (k <= 3) check("gate_no_issue", {63'd0, bank_rd_en}, 64'd0);
        end
        drain("gate");

        // Randomised traffic with random gating, stalls and foreign packets.
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 7) != 0),
                  ($urandom_range(0, 3) != 0),
                  {(($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 31)) : MY_TILE),
                   17'($urandom_range(0, 131071))},
                  ($urandom_range(0, 3) != 0));
        end
        drain("random");

        // Reset with two reads in flight: no response may follow.
        drive(1'b1, 1'b1, {MY_TILE, 17'h0BEEF}, 1'b1);
        drive(1'b1, 1'b1, {MY_TILE, 17'h0CAFE}, 1'b1);
        idle(1'b1);
        check("inflight_busy", {63'd0, busy}, 64'd1);
        do_reset();
        for (int k = 0; k < 6; k++) begin
            check("post_rst_valid", {63'd0, rdrs_rd_data_valid}, 64'd0);
            check("post_rst_busy", {63'd0, busy}, 64'd0);
            idle(1'b1);
        end
        check("post_rst_data", rdrs_rd_data, 64'd0);
        check("post_rst_ovf", {63'd0, err_overflow}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
